// File: rtl/video_fetch_pkg.sv
// Shared types for the video path: machine flavour, cell-fetch FSM states,
// pending-capture tags and the Spectrum screen/ULA+ address formers.
package common;

    typedef enum logic [1:0] {
        MACHINE_48K      = 2'd0,
        MACHINE_128K     = 2'd1,
        MACHINE_PLUS2A   = 2'd2,
        MACHINE_PENTAGON = 2'd3
    } machine_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BITMAP = 3'd1,
        ATTR   = 3'd2,
        INK    = 3'd3,
        PAPER  = 3'd4,
        DRAIN  = 3'd5
    } vfetch_state_t;

    typedef enum logic [2:0] {
        TAG_NONE   = 3'd0,
        TAG_BITMAP = 3'd1,
        TAG_ATTR   = 3'd2,
        TAG_INK    = 3'd3,
        TAG_PAPER  = 3'd4
    } vfetch_tag_t;

    // Screen RAM address of a cell's pixel byte (is_attr=0) or attribute byte (is_attr=1).
    function automatic logic [14:0] cell_addr(input logic [7:0] r, input logic [4:0] c,
                                              input logic is_attr);
        if (is_attr) begin
            cell_addr = {2'b00, 3'b110, r[7:3], c};
        end else begin
            cell_addr = {2'b00, r[7:6], r[2:0], r[5:3], c};
        end
    endfunction

    // ULA+ palette index: group from flash/bright, then ink (0..7) or paper (8..15).
    function automatic logic [14:0] palette_addr(input logic [7:0] a, input logic is_paper);
        if (is_paper) begin
            palette_addr = {9'b0, a[7:6], 1'b1, a[5:3]};
        end else begin
            palette_addr = {9'b0, a[7:6], 1'b0, a[2:0]};
        end
    endfunction

endpackage

// File: rtl/video_fetch.sv
// Fetches one 8-pixel character cell (bitmap, attribute and optionally the
// ULA+ ink/paper palette entries) through a preemptible RAM arbiter port.
module video_fetch
    import common::*;
(
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic [7:0]  row,
    input  logic [4:0]  col,
    input  logic        up_en,
    output logic        video_read_req,
    output logic        video_read_req_is_up,
    output logic [14:0] video_read_addr,
    input  logic        video_read_req_ack,
    input  logic        video_data_valid,
    input  logic [7:0]  vd,
    output logic [7:0]  bitmap,
    output logic [7:0]  attr,
    output logic [7:0]  ink_rgb,
    output logic [7:0]  paper_rgb,
    output logic        cell_ready,
    output logic        busy,
    output logic        overrun
);

    vfetch_state_t state_q, state_d;
    vfetch_tag_t   pend_q, pend_d;
    logic [7:0]    row_q, row_d;
    logic [4:0]    col_q, col_d;
    logic          up_q, up_d;
    logic          req_q, req_d;
    logic          is_up_q, is_up_d;
    logic [14:0]   addr_q, addr_d;
    logic [7:0]    bitmap_q, bitmap_d;
    logic [7:0]    attr_q, attr_d;
    logic [7:0]    ink_q, ink_d;
    logic [7:0]    paper_q, paper_d;
    logic          cell_ready_q, cell_ready_d;
    logic          busy_q, busy_d;
    logic          capture_s;

    assign capture_s = video_data_valid & (pend_q != TAG_NONE);

    // Next-state, request and capture logic for the cell fetch.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        row_d        = row_q;
        col_d        = col_q;
        up_d         = up_q;
        req_d        = req_q;
        is_up_d      = is_up_q;
        addr_d       = addr_q;
        bitmap_d     = bitmap_q;
        attr_d       = attr_q;
        ink_d        = ink_q;
        paper_d      = paper_q;
        cell_ready_d = 1'b0;

        if (capture_s) begin
            pend_d = TAG_NONE;
            case (pend_q)
                TAG_BITMAP: bitmap_d = vd;
                TAG_ATTR:   attr_d   = vd;
                TAG_INK:    ink_d    = vd;
                TAG_PAPER:  paper_d  = vd;
                default:    pend_d   = TAG_NONE;
            endcase
        end else begin
            pend_d = pend_q;
        end

        // An accepted item overwrites the tag after any capture in the same cycle.
        case (state_q)
            IDLE: begin
                if (fetch_start) begin
                    row_d   = row;
                    col_d   = col;
                    up_d    = up_en;
                    req_d   = 1'b1;
                    is_up_d = 1'b0;
                    addr_d  = cell_addr(row, col, 1'b0);
                    state_d = BITMAP;
                end else begin
                    req_d   = 1'b0;
                end
            end
            BITMAP: begin
                if (video_read_req_ack) begin
                    pend_d  = TAG_BITMAP;
                    addr_d  = cell_addr(row_q, col_q, 1'b1);
                    state_d = ATTR;
                end else begin
                    state_d = BITMAP;
                end
            end
            ATTR: begin
                if (video_read_req_ack) begin
                    pend_d  = TAG_ATTR;
                    req_d   = 1'b0;
                    state_d = up_q ? INK : DRAIN;
                end else begin
                    state_d = ATTR;
                end
            end
            INK: begin
                // req is low until the attribute lands; the ink index comes from it.
                if (!req_q) begin
                    if (capture_s && (pend_q == TAG_ATTR)) begin
                        req_d   = 1'b1;
                        is_up_d = 1'b1;
                        addr_d  = palette_addr(vd, 1'b0);
                    end else begin
                        state_d = INK;
                    end
                end else if (video_read_req_ack) begin
                    pend_d  = TAG_INK;
                    addr_d  = palette_addr(attr_q, 1'b1);
                    state_d = PAPER;
                end else begin
                    state_d = INK;
                end
            end
            PAPER: begin
                if (video_read_req_ack) begin
                    pend_d  = TAG_PAPER;
                    req_d   = 1'b0;
                    is_up_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    state_d = PAPER;
                end
            end
            DRAIN: begin
                if (capture_s) begin
                    cell_ready_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d      = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = TAG_NONE;
                req_d   = 1'b0;
                is_up_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any fetch in flight.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_q       <= TAG_NONE;
            row_q        <= 8'h00;
            col_q        <= 5'h00;
            up_q         <= 1'b0;
            req_q        <= 1'b0;
            is_up_q      <= 1'b0;
            addr_q       <= 15'h0000;
            bitmap_q     <= 8'h00;
            attr_q       <= 8'h00;
            ink_q        <= 8'h00;
            paper_q      <= 8'h00;
            cell_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            row_q        <= row_d;
            col_q        <= col_d;
            up_q         <= up_d;
            req_q        <= req_d;
            is_up_q      <= is_up_d;
            addr_q       <= addr_d;
            bitmap_q     <= bitmap_d;
            attr_q       <= attr_d;
            ink_q        <= ink_d;
            paper_q      <= paper_d;
            cell_ready_q <= cell_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign video_read_req       = req_q;
    assign video_read_req_is_up = is_up_q;
    assign video_read_addr      = addr_q;
    assign bitmap               = bitmap_q;
    assign attr                 = attr_q;
    assign ink_rgb              = ink_q;
    assign paper_rgb            = paper_q;
    assign cell_ready           = cell_ready_q;
    assign busy                 = busy_q;
    // Rejected starts are flagged in the cycle they are presented.
    assign overrun              = fetch_start & busy_q;

endmodule
